// File: rtl/config_spi_loader.sv
// config_spi_loader: SPI mode-0 slave that assembles 32-bit configuration words.
// All SPI pins are synchronised into clk_i and oversampled. Every complete word
// is presented on bitstream_data_o with a single-cycle bitstream_valid_o pulse.
// SyncStages must be at least 2.
module config_spi_loader #(
   parameter int unsigned SyncStages = 2,
   parameter int unsigned CountWidth = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  spi_sck_i,
   input  logic                  spi_cs_ni,
   input  logic                  spi_mosi_i,
   output logic [31:0]           bitstream_data_o,
   output logic                  bitstream_valid_o,
   output logic                  active_o,
   output logic [CountWidth-1:0] word_count_o,
   output logic                  frame_error_o
);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RECV = 1'b1
   } state_t;

   localparam logic [CountWidth-1:0] CNT_ZERO = {CountWidth{1'b0}};
   localparam logic [CountWidth-1:0] CNT_MAX  = {CountWidth{1'b1}};
   localparam logic [CountWidth-1:0] CNT_ONE  = {{(CountWidth-1){1'b0}}, 1'b1};

   // Synchroniser chains and edge-detect history
   logic [SyncStages-1:0] sck_sync_r;
   logic [SyncStages-1:0] cs_sync_r;
   logic [SyncStages-1:0] mosi_sync_r;
   logic                  sck_prev_r;
   logic                  cs_prev_r;

   logic sck_s;
   logic cs_s;
   logic mosi_s;
   logic sck_rise_s;
   logic cs_fall_s;
   logic cs_rise_s;

   // FSM and datapath state
   state_t           state_r;
   state_t           state_next_s;
   logic             frame_start_s;
   logic             frame_end_s;
   logic             shift_en_s;
   logic             word_done_s;
   logic [30:0]      shift_r;
   logic [4:0]       bit_cnt_r;
   logic [31:0]      data_r;
   logic             valid_r;
   logic             active_r;
   logic [CountWidth-1:0] word_count_r;
   logic             frame_error_r;

   // Bring the asynchronous SPI pins into the clk_i domain; CS resets to deasserted
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sck_sync_r  <= {SyncStages{1'b0}};
         cs_sync_r   <= {SyncStages{1'b1}};
         mosi_sync_r <= {SyncStages{1'b0}};
      end else begin
         sck_sync_r  <= {sck_sync_r[SyncStages-2:0], spi_sck_i};
         cs_sync_r   <= {cs_sync_r[SyncStages-2:0], spi_cs_ni};
         mosi_sync_r <= {mosi_sync_r[SyncStages-2:0], spi_mosi_i};
      end
   end

   assign sck_s  = sck_sync_r[SyncStages-1];
   assign cs_s   = cs_sync_r[SyncStages-1];
   assign mosi_s = mosi_sync_r[SyncStages-1];

   // Remember the previous synchronised SCK/CS level for edge detection
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sck_prev_r <= 1'b0;
         cs_prev_r  <= 1'b1;
      end else begin
         sck_prev_r <= sck_s;
         cs_prev_r  <= cs_s;
      end
   end

   assign sck_rise_s = sck_s & ~sck_prev_r;
   assign cs_fall_s  = ~cs_s & cs_prev_r;
   assign cs_rise_s  = cs_s & ~cs_prev_r;

   // FSM state register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state and control strobes; a CS release beats a coincident SCK edge
   always_comb begin
      state_next_s  = state_r;
      frame_start_s = 1'b0;
      frame_end_s   = 1'b0;
      shift_en_s    = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (cs_fall_s) begin
               state_next_s  = S_RECV;
               frame_start_s = 1'b1;
            end else begin
               state_next_s = S_IDLE;
            end
         end
         S_RECV: begin
            if (cs_rise_s) begin
               state_next_s = S_IDLE;
               frame_end_s  = 1'b1;
            end else if (sck_rise_s) begin
               state_next_s = S_RECV;
               shift_en_s   = 1'b1;
            end else begin
               state_next_s = S_RECV;
            end
         end
         default: begin
            state_next_s = S_IDLE;
         end
      endcase
   end

   assign word_done_s = shift_en_s & (bit_cnt_r == 5'd31);

   // Shift register and bit position within the current word
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         shift_r   <= 31'd0;
         bit_cnt_r <= 5'd0;
      end else if (frame_start_s || frame_end_s) begin
         bit_cnt_r <= 5'd0;
      end else if (shift_en_s) begin
         shift_r   <= {shift_r[29:0], mosi_s};
         bit_cnt_r <= bit_cnt_r + 5'd1;
      end
   end

   // Word output register and one-cycle valid strobe
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         data_r  <= 32'd0;
         valid_r <= 1'b0;
      end else begin
         valid_r <= word_done_s;
         if (word_done_s) begin
            data_r <= {shift_r, mosi_s};
         end
      end
   end

   // Per-frame status: active flag, saturating word counter, sticky partial-word error
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         active_r      <= 1'b0;
         word_count_r  <= CNT_ZERO;
         frame_error_r <= 1'b0;
      end else begin
         active_r <= (state_next_s == S_RECV);
         if (frame_start_s) begin
            word_count_r  <= CNT_ZERO;
            frame_error_r <= 1'b0;
         end else if (frame_end_s) begin
            frame_error_r <= frame_error_r | (bit_cnt_r != 5'd0);
         end else if (word_done_s && (word_count_r != CNT_MAX)) begin
            word_count_r <= word_count_r + CNT_ONE;
         end
      end
   end

   assign bitstream_data_o  = data_r;
   assign bitstream_valid_o = valid_r;
   assign active_o          = active_r;
   assign word_count_o      = word_count_r;
   assign frame_error_o     = frame_error_r;

endmodule

// File: doc/config_spi_loader.md
Name: config_spi_loader

Overview:
- SPI-mode-0 slave that turns an external serial configuration stream into 32-bit bitstream words.
- Drives the bitstream word/valid inputs of the fabric configuration controller, one single-cycle valid pulse per complete word.
- All SPI pins are asynchronous to clk_i. They are synchronised internally and oversampled; no second clock domain exists inside the block.
- No backpressure: the downstream controller accepts a word on every cycle.

Parameters:
- SyncStages, 2, number of flops in each input synchroniser chain, minimum 2.
- CountWidth, 16, width of the per-frame received-word counter.

Ports:
- clk_i  input  1  system clock.
- rst_ni  input  1  asynchronous active-low reset.
- spi_sck_i  input  1  SPI clock, idle low, asynchronous.
- spi_cs_ni  input  1  SPI chip select, active low, asynchronous.
- spi_mosi_i  input  1  SPI data, MSB first, asynchronous.
- bitstream_data_o  output  32  last completed word; holds its value between words.
- bitstream_valid_o  output  1  one-cycle pulse, bitstream_data_o valid.
- active_o  output  1  synchronised chip select is asserted (frame in progress).
- word_count_o  output  CountWidth  words received in the current/last frame, saturating.
- frame_error_o  output  1  sticky: last frame ended with a partial word.

Behaviour:
- Reset (async, rst_ni=0): all outputs 0.
  - Synchroniser flops reset to: sck 0, cs 1, mosi 0.
  - FSM in S_IDLE; shift register and bit counter cleared.
  - Reset mid-word discards the partial word, and no valid is emitted.
- Synchronisation:
  - Each pin passes through SyncStages flops, giving sck_s, cs_s, mosi_s.
  - One extra register each on sck_s and cs_s supports edge detection.
  - sck_rise = sck_s & ~sck_q. cs_fall = ~cs_s & cs_q. cs_rise = cs_s & ~cs_q.
  - Requirement on the SPI master: SCK high and low phases are each ≥ 2 clk_i periods; MOSI is stable ≥ 2 clk_i before the SCK rising edge; CS setup/hold to the first/last SCK edge is ≥ 2 clk_i.
- FSM S_IDLE:
  - active_o=0; sck_rise is ignored.
  - On cs_fall: go to S_RECV, clear bit_cnt, clear word_count_o, clear frame_error_o.
- FSM S_RECV:
  - active_o=1.
  - On sck_rise: shift_q <= {shift_q[30:0], mosi_s}; bit_cnt (5 bits) increments and wraps 31→0.
  - When sck_rise occurs with bit_cnt==31:
    - bitstream_data_o <= {shift_q[30:0], mosi_s} on the next edge.
    - bitstream_valid_o=1 for exactly that one cycle.
    - word_count_o increments, saturating at 2^CountWidth-1.
  - Latency: valid is high in the cycle after the cycle in which sck_rise is high.
  - On cs_rise: go to S_IDLE. If bit_cnt != 0, set frame_error_o=1 and discard the partial word; bit_cnt clears.
- Simultaneous cs_rise and sck_rise in one cycle: cs_rise wins; the edge is not shifted and no valid is produced.
- Back-to-back words within one frame need no gap: bit 0 of word N+1 may follow bit 31 of word N at full SCK rate.
- word_count_o and frame_error_o hold their values in S_IDLE until the next cs_fall.
- bitstream_valid_o is never high in two consecutive cycles, given the SCK timing requirement.
- Data content is not interpreted; the sync word and headers pass through unchanged.

Test Plan:
- Word capture: CS low, shift 0xFAB0FAB1 MSB first at clk/8, CS high → one valid pulse, data=0xFAB0FAB1, word_count_o=1, frame_error_o=0.
- Back-to-back: one frame carrying 0xFAB0FAB1, 0x00000005, 0xDEADBEEF with no gaps → three single-cycle pulses in order with matching data, word_count_o=3.
- Partial word:
  - CS low, 12 SCK edges, CS high → no valid pulse, frame_error_o=1, word_count_o=0.
  - Next frame's cs_fall → frame_error_o=0; a full word then captures correctly.
- Counter saturation: CountWidth=2, send 5 words in one frame → five valid pulses, word_count_o=3 after the 3rd word and stays 3.
- CS gating: 40 SCK edges with CS high → no valid, active_o=0, data stays 0.
  - CS edge collision: CS deasserts in the same synchronised cycle as the 32nd SCK rise → no valid, frame_error_o=1.
- Reset mid-word: assert rst_ni=0 after 20 bits → all outputs 0 immediately (asynchronous); release, new frame with 0x12345678 → data=0x12345678, word_count_o=1.
